rnm_adc_sampler: RTL and testbench

RNM_ADC_SAMPLER -- requirements
Module: rnm_adc_sampler

---
 rtl/rnm_pkg.sv | 25 ++
 rtl/rnm_sync_fifo.sv | 52 +++++
 rtl/rnm_adc_sampler.sv | 73 +++++++
 tb/tb_rnm_adc_sampler.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rnm_pkg.sv
// Shared constants and the quantizer used by the RNM ADC sampler.
// Every module that needs the default ranges or the code conversion imports this package.
package rnm_pkg;

  localparam real VREF_LO_DEF = 0.0;
  localparam real VREF_HI_DEF = 1.0;
  localparam real TH_LO_DEF   = 0.4;
  localparam real TH_HI_DEF   = 0.6;
  localparam int  DROP_W      = 8;

  typedef logic [DROP_W-1:0] drop_t;

  // floor((v-lo)/(hi-lo)*2^nbits), clamped to 0..2^nbits-1; NaN maps to 0
  function automatic int quantize(real v, real lo, real hi, int nbits);
    real x;
    int  top;
    top = (1 << nbits) - 1;
    x   = (v - lo) / (hi - lo) * real'(1 << nbits);
    if (x != x) return 0;
    if (x <= 0.0) return 0;
    if (x >= real'(top)) return top;
    return $rtoi(x);
  endfunction

endpackage

// File: rtl/rnm_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter so full and empty never alias.
// A push while full is accepted only when a pop happens on the same edge.
module rnm_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic          do_push, do_pop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives the modulo wrap for free
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/rnm_adc_sampler.sv
// Real-number-model ADC: divided sample tick, quantizer, hysteresis comparator and output FIFO.
// Samples that find the FIFO full (with no pop on the same edge) are dropped and counted.
module rnm_adc_sampler
  import rnm_pkg::*;
#(
  parameter int  DIV     = 4,
  parameter int  NBITS   = 8,
  parameter int  DEPTH   = 4,
  parameter real VREF_LO = VREF_LO_DEF,
  parameter real VREF_HI = VREF_HI_DEF,
  parameter real TH_LO   = TH_LO_DEF,
  parameter real TH_HI   = TH_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              vin,
  output logic [NBITS-1:0] code_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             level_o,
  output logic [7:0]       drop_cnt_o
);
  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

  logic [7:0]       cnt;
  logic             tick, pop, fifo_full, fifo_empty;
  logic [NBITS-1:0] qcode;

  // A reset edge never produces a tick, so nothing is pushed alongside the clear
  assign tick = en && !rst && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + 8'd1;
  end

  always_comb begin
    qcode = NBITS'(quantize(vin, VREF_LO, VREF_HI, NBITS));
  end

  assign valid_o = !fifo_empty;
  assign pop     = valid_o && ready_i;

  rnm_sync_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tick),
    .wdata (qcode),
    .pop   (pop),
    .rdata (code_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_o <= '0;
    else if (tick && fifo_full && !pop && drop_cnt_o != 8'hFF)
      drop_cnt_o <= drop_cnt_o + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      level_o <= 1'b0;
    else if (tick) begin
      if (vin >= TH_HI)      level_o <= 1'b1;
      else if (vin <= TH_LO) level_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rnm_adc_sampler.sv
// Bench for rnm_adc_sampler: quantizer vector table, directed corner sequences,
// and randomized traffic checked every cycle against a queue-based behavioural model.
module tb_rnm_adc_sampler;
  localparam int DIV = 4, NB = 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst, en, ready_i;
  real           vin;
  logic [NB-1:0] code_o;
  logic          valid_o, level_o;
  logic [7:0]    drop_cnt_o;

  int         total = 0, bad = 0;
  logic [7:0] mq[$];
  int         mn, mdrop;
  logic       mlevel;
  string      ctx;

  typedef struct { real vin; int code; } qvec_t;
  qvec_t tbl[10];

  rnm_adc_sampler #(.DIV(DIV), .NBITS(NB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vin        (vin),
    .code_o     (code_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_code(real v);
    real x;
    if (v != v) return 8'd0;
    x = $floor(v * 256.0);
    if (x < 0.0) return 8'd0;
    if (x > 255.0) return 8'd255;
    return 8'(int'(x));
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d want %0d", ctx, name, act, exp);
    end
  endtask

  // Model: a queue of codes; a tick is every DIV-th consecutive enabled edge
  task automatic model_edge();
    bit pop, tick;
    int sz;
    if (rst) begin
      mq.delete(); mn = 0; mlevel = 1'b0; mdrop = 0;
      return;
    end
    sz   = mq.size();
    pop  = (sz > 0) && ready_i;
    tick = en && ((mn + 1) % DIV == 0);
    if (pop) void'(mq.pop_front());
    if (tick) begin
      if (sz < DEPTH || pop) mq.push_back(ref_code(vin));
      else if (mdrop < 255) mdrop++;
      if (vin >= 0.6) mlevel = 1'b1;
      else if (vin <= 0.4) mlevel = 1'b0;
    end
    mn = en ? mn + 1 : 0;
  endtask

  task automatic step(input logic r, input logic e, input real v, input logic rd);
    rst = r; en = e; vin = v; ready_i = rd;
    model_edge();
    @(posedge clk); #1;
    chk("m_valid", valid_o, mq.size() > 0);
    chk("m_code",  code_o,  mq.size() > 0 ? mq[0] : 0);
    chk("m_level", level_o, mlevel);
    chk("m_drop",  drop_cnt_o, mdrop);
  endtask

  real  nan, zero, v;
  int   k, npulse;
  int   exp_codes[4];

  initial begin
    rst = 1'b1; en = 1'b0; vin = 0.0; ready_i = 1'b0;
    zero = 0.0; nan = zero / zero;
    tbl[0] = '{0.5, 128};   tbl[1] = '{1.2, 255};  tbl[2] = '{-0.1, 0};
    tbl[3] = '{0.999, 255}; tbl[4] = '{0.0, 0};    tbl[5] = '{0.25, 64};
    tbl[6] = '{0.7, 179};   tbl[7] = '{0.00390625, 1};
    tbl[8] = '{0.99609375, 255}; tbl[9] = '{0.0, 0};
    tbl[9].vin = nan;

    ctx = "reset";
    step(1'b1, 1'b0, 0.0, 1'b0);
    chk("valid", valid_o, 0); chk("code", code_o, 0);
    chk("level", level_o, 0); chk("drop", drop_cnt_o, 0);

    ctx = "table";
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 0.0, 1'b0);
      for (int c = 0; c < DIV; c++) step(1'b0, 1'b1, tbl[i].vin, 1'b1);
      chk($sformatf("valid%0d", i), valid_o, 1);
      chk($sformatf("code%0d", i), code_o, tbl[i].code);
    end

    ctx = "pulse";
    step(1'b1, 1'b0, 0.0, 1'b1);
    npulse = 0;
    for (int s = 1; s <= 12; s++) begin
      step(1'b0, 1'b1, 0.5, 1'b1);
      chk($sformatf("valid_s%0d", s), valid_o, (s % DIV) == 0);
      if (valid_o) begin
        npulse++;
        chk("code128", code_o, 128);
      end
    end
    chk("npulse", npulse, 3);

    ctx = "overflow";
    step(1'b1, 1'b0, 0.0, 1'b0);
    for (int s = 1; s <= 20; s++) step(1'b0, 1'b1, s * 0.04, 1'b0);
    chk("drop20", drop_cnt_o, 1);
    for (int s = 21; s <= 23; s++) step(1'b0, 1'b1, s * 0.04, 1'b0);
    chk("head40", code_o, 40);
    step(1'b0, 1'b1, 24 * 0.04, 1'b1);
    chk("drop24", drop_cnt_o, 1);
    exp_codes = '{81, 122, 163, 245};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dvalid%0d", i), valid_o, 1);
      chk($sformatf("dcode%0d", i), code_o, exp_codes[i]);
      step(1'b0, 1'b0, 0.0, 1'b1);
    end
    chk("empty", valid_o, 0);

    ctx = "hyst";
    step(1'b1, 1'b0, 0.0, 1'b1);
    for (int j = 0; j <= 40; j++) begin
      k = (j <= 20) ? j : 40 - j;
      v = k / 20.0;
      for (int c = 0; c < DIV; c++) step(1'b0, 1'b1, v, 1'b1);
      chk($sformatf("lvl%0d", j), level_o, (j <= 20) ? (k >= 12) : (k >= 9));
    end

    ctx = "midreset";
    step(1'b1, 1'b0, 0.0, 1'b0);
    for (int s = 0; s < 14; s++) step(1'b0, 1'b1, 0.9, 1'b0);
    chk("pre_level", level_o, 1);
    step(1'b1, 1'b1, 0.9, 1'b0);
    chk("valid", valid_o, 0); chk("code", code_o, 0);
    chk("level", level_o, 0); chk("drop", drop_cnt_o, 0);
    for (int s = 1; s <= DIV; s++) begin
      step(1'b0, 1'b1, 0.9, 1'b1);
      chk($sformatf("first_s%0d", s), valid_o, s == DIV);
    end

    ctx = "saturate";
    step(1'b1, 1'b0, 0.0, 1'b0);
    for (int s = 0; s < 1100; s++) step(1'b0, 1'b1, 0.3, 1'b0);
    chk("drop255", drop_cnt_o, 255);

    ctx = "random";
    step(1'b1, 1'b0, 0.0, 1'b0);
    for (int s = 0; s < 2000; s++) begin
      if ($urandom_range(0, 49) == 0) v = nan;
      else v = $urandom_range(0, 1400) / 1000.0 - 0.2;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, v,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
